// File: rtl/stack_pkg.sv
// stack_pkg
//   Shared definitions for the stack-operation sequencer.
//   - stack_op_e    : command encodings presented on stack_seq.op
//   - stack_state_e : sequencer FSM states
package stack_pkg;

  typedef enum logic [1:0] {
    ST_PUSH = 2'd0,
    ST_POP  = 2'd1,
    ST_ADJ  = 2'd2,
    ST_SET  = 2'd3
  } stack_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } stack_state_e;

endpackage

// File: rtl/stack_prio_enc.sv
// stack_prio_enc
//   Priority encoder over a W-bit register list with selectable direction.
//   Ports:
//     vec    in  W   bit vector to encode
//     dir_hi in  1   1 = report highest set bit, 0 = report lowest set bit
//     idx    out IW  index of the selected bit (0 when none set)
//     valid  out 1   at least one bit of vec is set
module stack_prio_enc #(
  parameter int W  = 9,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  input  logic          dir_hi,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Last match in the scan wins, so the scan order picks the direction.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    if (dir_hi) begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) begin
          idx   = IW'(i);
          valid = 1'b1;
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = IW'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stack_seq.sv
// stack_seq
//   Stack-operation sequencer. Owns SP and expands multi-register PUSH/POP
//   into single-word memory transfers over a req/ack handshake. Commands
//   that would leave SP outside [SP_LIMIT, SP_BASE] are rejected with a
//   fault pulse before any memory access.
//   Ports:
//     clk, resetn         clock, asynchronous active-low reset
//     start, op, reglist  command strobe, opcode, register list (bit NREG = LR/PC)
//     imm                 signed word count (ADJ) or absolute SP (SET)
//     mem_ack             memory accepted store / load data valid
//     busy, done, fault   status: in progress, completion pulse, reject pulse
//     mem_req, mem_we     transfer request, 1 = store
//     mem_addr            transfer address
//     reg_idx, lr_sel     register being moved, store data from LR
//     rf_we, pc_we        load data write strobes (regfile / PC)
//     sp_out              current stack pointer
module stack_seq
  import stack_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                NREG       = 8,
  parameter int                WORD_BYTES = 4,
  parameter logic [ADDR_W-1:0] SP_RESET   = 16'h5500,
  parameter logic [ADDR_W-1:0] SP_BASE    = 16'h5500,
  parameter logic [ADDR_W-1:0] SP_LIMIT   = 16'h4500
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [NREG:0]             reglist,
  input  logic [ADDR_W-1:0]         imm,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [$clog2(NREG+1)-1:0] reg_idx,
  output logic                      lr_sel,
  output logic                      rf_we,
  output logic                      pc_we,
  output logic [ADDR_W-1:0]         sp_out
);

  localparam int LW    = NREG + 1;
  localparam int IDX_W = $clog2(NREG + 1);
  localparam int SH    = $clog2(WORD_BYTES);
  localparam int CNT_W = $clog2(NREG + 2);
  // Two guard bits: one for carry/borrow, one for sign.
  localparam int EXT_W = ADDR_W + SH + 2;

  localparam logic [ADDR_W-1:0]       WB         = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0]       ALIGN_MASK = WB - ADDR_W'(1);
  localparam logic [IDX_W-1:0]        LR_IDX     = IDX_W'(NREG);
  localparam logic signed [EXT_W-1:0] LIM_EXT    = $signed(EXT_W'(SP_LIMIT));
  localparam logic signed [EXT_W-1:0] BASE_EXT   = $signed(EXT_W'(SP_BASE));

  function automatic logic [CNT_W-1:0] popcount(input logic [LW-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LW; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Results are computed with guard bits, so a borrow shows up as a
  // negative value and a carry as a value above SP_BASE.
  function automatic logic above_limit(input logic signed [EXT_W-1:0] v);
    return v >= LIM_EXT;
  endfunction

  function automatic logic below_base(input logic signed [EXT_W-1:0] v);
    return v <= BASE_EXT;
  endfunction

  stack_state_e state_q, state_d;
  stack_op_e    op_q, op_in;
  logic [LW-1:0]     work_q, list_d;
  logic [ADDR_W-1:0] sp_q, sp_d;

  logic signed [EXT_W-1:0] sp_ext, nb_ext, imm_ext;
  logic signed [EXT_W-1:0] push_res, pop_res, adj_res;
  logic                    set_ok, cmd_ok;
  logic                    accept, pushpop, go_xfer, go_imm, bad;
  logic                    xfer_ack, dir_hi;
  logic [IDX_W-1:0]        enc_idx;
  logic                    enc_vld;

  // ---- Start-cycle command decode and bounds check ----
  assign op_in    = stack_op_e'(op);
  assign sp_ext   = $signed(EXT_W'(sp_q));
  assign nb_ext   = $signed(EXT_W'(popcount(reglist))) <<< SH;
  assign imm_ext  = $signed({{(EXT_W - ADDR_W){imm[ADDR_W-1]}}, imm}) <<< SH;
  assign push_res = sp_ext - nb_ext;
  assign pop_res  = sp_ext + nb_ext;
  assign adj_res  = sp_ext + imm_ext;
  assign set_ok   = ((imm & ALIGN_MASK) == '0) && (imm >= SP_LIMIT) && (imm <= SP_BASE);

  always_comb begin
    cmd_ok = 1'b0;
    case (op_in)
      ST_PUSH: cmd_ok = above_limit(push_res);
      ST_POP:  cmd_ok = below_base(pop_res);
      ST_ADJ:  cmd_ok = imm_ext[EXT_W-1] ? above_limit(adj_res) : below_base(adj_res);
      default: cmd_ok = set_ok;
    endcase
  end

  assign accept   = (state_q == IDLE) && start;
  assign pushpop  = (op_in == ST_PUSH) || (op_in == ST_POP);
  assign go_xfer  = accept && cmd_ok && pushpop;
  assign go_imm   = accept && cmd_ok && !pushpop;
  assign bad      = accept && !cmd_ok;
  assign xfer_ack = (state_q == XFER) && mem_req && mem_ack;
  // Direction must be known in the start cycle, before op_q is loaded.
  assign dir_hi   = go_xfer ? (op_in == ST_PUSH) : (op_q == ST_PUSH);

  // ---- Next working list and SP ----
  always_comb begin
    list_d = work_q;
    sp_d   = sp_q;
    if (go_xfer) begin
      list_d = reglist;
    end else if (go_imm) begin
      sp_d = (op_in == ST_ADJ) ? adj_res[ADDR_W-1:0] : imm;
    end else if (xfer_ack) begin
      list_d = work_q & ~(LW'(1) << reg_idx);
      sp_d   = (op_q == ST_PUSH) ? (sp_q - WB) : (sp_q + WB);
    end
  end

  // The encoder looks at the next list so the following transfer's
  // index can be registered on the same edge that retires this one.
  stack_prio_enc #(
    .W  (LW),
    .IW (IDX_W)
  ) u_prio_enc (
    .vec    (list_d),
    .dir_hi (dir_hi),
    .idx    (enc_idx),
    .valid  (enc_vld)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_xfer) state_d = enc_vld ? XFER : FIN;
      XFER:    if (xfer_ack && !enc_vld) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- Registered state and memory-port outputs ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= ST_PUSH;
      work_q   <= '0;
      sp_q     <= SP_RESET;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      reg_idx  <= '0;
      lr_sel   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= list_d;
      sp_q    <= sp_d;
      done    <= go_imm || (state_q == FIN);
      fault   <= bad;
      if (go_xfer) begin
        op_q   <= op_in;
        busy   <= 1'b1;
        mem_we <= (op_in == ST_PUSH);
      end else if (state_q == FIN) begin
        busy <= 1'b0;
      end
      // While stalled, list_d and sp_d hold, so these reload unchanged.
      if (state_d == XFER) begin
        mem_req  <= 1'b1;
        mem_addr <= dir_hi ? (sp_d - WB) : sp_d;
        reg_idx  <= enc_idx;
        lr_sel   <= dir_hi && (enc_idx == LR_IDX);
      end else begin
        mem_req <= 1'b0;
        lr_sel  <= 1'b0;
      end
    end
  end

  assign sp_out = sp_q;
  assign rf_we  = mem_req && !mem_we && mem_ack && (reg_idx != LR_IDX);
  assign pc_we  = mem_req && !mem_we && mem_ack && (reg_idx == LR_IDX);

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq
//   Scoreboard bench for stack_seq with default parameters. Stimulus pushes
//   hand-computed expected events (transfer, done, fault); a monitor pops
//   and compares them whenever the DUT presents one.
module tb_stack_seq;
  import stack_pkg::*;

  localparam int EV_XFER  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [3:0]  idx;
    logic        we;
    logic        lr;
    logic        rfwe;
    logic        pcwe;
    logic [15:0] sp;
  } ev_t;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [8:0]  reglist;
  logic [15:0] imm;
  logic        mem_ack;
  logic        busy, done, fault, mem_req, mem_we, lr_sel, rf_we, pc_we;
  logic [15:0] mem_addr, sp_out;
  logic [3:0]  reg_idx;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  stack_seq dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .reglist  (reglist),
    .imm      (imm),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .reg_idx  (reg_idx),
    .lr_sel   (lr_sel),
    .rf_we    (rf_we),
    .pc_we    (pc_we),
    .sp_out   (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_x(input logic [15:0] a, input logic [3:0] i, input logic we,
                       input logic lr, input logic rf, input logic pc, input logic [15:0] sp);
    ev_t e;
    e.kind = EV_XFER; e.addr = a; e.idx = i; e.we = we;
    e.lr = lr; e.rfwe = rf; e.pcwe = pc; e.sp = sp;
    exp_q.push_back(e);
  endtask

  task automatic exp_end(input int kind, input logic [15:0] sp);
    ev_t e;
    e.kind = kind; e.addr = '0; e.idx = '0; e.we = 1'b0;
    e.lr = 1'b0; e.rfwe = 1'b0; e.pcwe = 1'b0; e.sp = sp;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [8:0] l, input logic [15:0] i,
                       input logic ack);
    @(posedge clk); #1;
    start = 1'b1; op = o; reglist = l; imm = i; mem_ack = ack;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles after the start edge until done or fault is seen.
  task automatic wait_evt(output int cyc, output logic busy_c1, output logic req_seen);
    cyc = 0; busy_c1 = 1'b0; req_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) busy_c1 = busy;
      if (mem_req) req_seen = 1'b1;
      if (done || fault) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done/fault within 40 cycles");
    end
  endtask

  // Monitor
  initial begin
    ev_t e;
    int  k;
    forever begin
      @(negedge clk);
      if (resetn && ((mem_req && mem_ack) || done || fault)) begin
        k = (mem_req && mem_ack) ? EV_XFER : (done ? EV_DONE : EV_FAULT);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_event: got kind %0d, expected no event", k);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_sp", sp_out, e.sp);
          if (k == EV_XFER && e.kind == EV_XFER) begin
            chk("xfer_addr", mem_addr, e.addr);
            chk("xfer_idx", reg_idx, e.idx);
            chk("xfer_we", mem_we, e.we);
            chk("xfer_lr_sel", lr_sel, e.lr);
            chk("xfer_rf_we", rf_we, e.rfwe);
            chk("xfer_pc_we", pc_we, e.pcwe);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int   cyc;
    logic b1, rq;
    resetn = 1'b0; start = 1'b0; op = 2'd0; reglist = '0; imm = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sp", sp_out, 16'h5500);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_reg_idx", reg_idx, 0);
    chk("rst_done_fault", {done, fault, lr_sel, mem_we}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // PUSH LR, r2, r0 with ack tied high
    exp_x(16'h54FC, 4'd8, 1, 1, 0, 0, 16'h5500);
    exp_x(16'h54F8, 4'd2, 1, 0, 0, 0, 16'h54FC);
    exp_x(16'h54F4, 4'd0, 1, 0, 0, 0, 16'h54F8);
    exp_end(EV_DONE, 16'h54F4);
    issue(ST_PUSH, 9'b1_0000_0101, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("push_latency", cyc, 5);
    chk("push_busy_c1", b1, 1);
    chk("push_busy_at_done", busy, 0);

    // POP r0, r2, PC
    exp_x(16'h54F4, 4'd0, 0, 0, 1, 0, 16'h54F4);
    exp_x(16'h54F8, 4'd2, 0, 0, 1, 0, 16'h54F8);
    exp_x(16'h54FC, 4'd8, 0, 0, 0, 1, 16'h54FC);
    exp_end(EV_DONE, 16'h5500);
    issue(ST_POP, 9'b1_0000_0101, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("pop_latency", cyc, 5);

    // PUSH r3 with a 3-cycle stall
    exp_x(16'h54FC, 4'd3, 1, 0, 0, 0, 16'h5500);
    exp_end(EV_DONE, 16'h54FC);
    issue(ST_PUSH, 9'b0_0000_1000, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 16'h54FC);
      chk("stall_sp", sp_out, 16'h5500);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    wait_evt(cyc, b1, rq);
    chk("stall_done_after_ack", cyc, 3);

    exp_x(16'h54FC, 4'd3, 0, 0, 1, 0, 16'h54FC);
    exp_end(EV_DONE, 16'h5500);
    issue(ST_POP, 9'b0_0000_1000, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);

    // Underflow and misaligned SET
    exp_end(EV_FAULT, 16'h5500);
    issue(ST_POP, 9'b0_0000_0001, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("underflow_latency", cyc, 1);
    chk("underflow_no_req", rq, 0);
    exp_end(EV_FAULT, 16'h5500);
    issue(ST_SET, 9'h0, 16'h5502, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("set_misaligned_fault", fault, 1);

    // ADJ down/up, then empty PUSH
    exp_end(EV_DONE, 16'h54C0);
    issue(ST_ADJ, 9'h0, 16'hFFF0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("adj_latency", cyc, 1);
    chk("adj_no_busy", b1, 0);
    exp_end(EV_DONE, 16'h5500);
    issue(ST_ADJ, 9'h0, 16'h0010, 1'b1);
    wait_evt(cyc, b1, rq);
    exp_end(EV_DONE, 16'h5500);
    issue(ST_PUSH, 9'h0, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("push0_latency", cyc, 2);
    chk("push0_no_req", rq, 0);

    // Boundaries at SP_LIMIT and SP_BASE
    exp_end(EV_DONE, 16'h4500);
    issue(ST_SET, 9'h0, 16'h4500, 1'b1);
    wait_evt(cyc, b1, rq);
    exp_end(EV_FAULT, 16'h4500);
    issue(ST_PUSH, 9'b0_0000_0001, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("overflow_no_req", rq, 0);
    exp_end(EV_FAULT, 16'h4500);
    issue(ST_ADJ, 9'h0, 16'hFFFF, 1'b1);
    wait_evt(cyc, b1, rq);
    exp_end(EV_FAULT, 16'h4500);
    issue(ST_SET, 9'h0, 16'h5504, 1'b1);
    wait_evt(cyc, b1, rq);
    exp_end(EV_DONE, 16'h4504);
    issue(ST_SET, 9'h0, 16'h4504, 1'b1);
    wait_evt(cyc, b1, rq);
    exp_x(16'h4500, 4'd0, 1, 0, 0, 0, 16'h4504);
    exp_end(EV_DONE, 16'h4500);
    issue(ST_PUSH, 9'b0_0000_0001, 16'h0, 1'b1);
    wait_evt(cyc, b1, rq);
    chk("push_at_limit_sp", sp_out, 16'h4500);

    // Reset in the middle of a stalled PUSH
    exp_end(EV_DONE, 16'h5500);
    issue(ST_SET, 9'h0, 16'h5500, 1'b1);
    wait_evt(cyc, b1, rq);
    issue(ST_PUSH, 9'b0_0000_0010, 16'h0, 1'b0);
    @(negedge clk);
    chk("midrst_req_before", mem_req, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_sp", sp_out, 16'h5500);
    chk("midrst_busy", busy, 0);
    chk("midrst_req", mem_req, 0);
    chk("midrst_addr", mem_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("after_rst_sp", sp_out, 16'h5500);
    chk("after_rst_req", mem_req, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Parametrised stack-operation sequencer for the processor's stack unit. It owns the stack pointer and expands multi-register PUSH/POP into a sequence of single-word data-memory transfers over a request/acknowledge handshake. It adds two things per-bit stepping lacked: register lists of any width that skip cleared bits, and bounds checking that reports overflow/underflow before any memory access. It sits between instruction decode (start/op/list), the register file, PC/LR muxing, and the data-memory port.

## Interface

Parameters:
- ADDR_W, 16: stack-pointer and memory address width.
- NREG, 8: general registers covered by the list; list bit NREG selects LR on push and PC on pop.
- WORD_BYTES, 4: byte stride per transfer, a power of two.
- SP_RESET, 16'h5500: SP value after reset.
- SP_BASE, 16'h5500: highest legal SP (empty stack).
- SP_LIMIT, 16'h4500: lowest legal SP (full stack).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  command strobe, accepted only when busy=0.
- op  in  2  0=PUSH, 1=POP, 2=ADJ (SP += imm·WORD_BYTES), 3=SET (SP = imm).
- reglist  in  NREG+1  register list for PUSH/POP.
- imm  in  ADDR_W  signed word count (ADJ) or absolute SP (SET).
- mem_ack  in  1  memory accepted the write, or read data is valid.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- fault  out  1  one-cycle pulse; command rejected with no side effects.
- mem_req  out  1  transfer request.
- mem_we  out  1  1=store (PUSH), 0=load (POP).
- mem_addr  out  ADDR_W  transfer address.
- reg_idx  out  $clog2(NREG+1)  register being stored or loaded.
- lr_sel  out  1  store data comes from LR (reg_idx==NREG during PUSH).
- rf_we  out  1  write load data to register reg_idx.
- pc_we  out  1  write load data to PC (reg_idx==NREG during POP).
- sp_out  out  ADDR_W  current SP.

## Operation

- States: IDLE, XFER, FIN.
- IDLE + start: latch op and reglist, and compute n = popcount(reglist).
- Bounds check in the start cycle:
  - PUSH is legal if SP − n·WORD_BYTES ≥ SP_LIMIT with no borrow.
  - POP is legal if SP + n·WORD_BYTES ≤ SP_BASE with no carry.
  - ADJ uses the same checks on the signed result.
  - SET is legal if imm is WORD_BYTES-aligned and in [SP_LIMIT, SP_BASE].
- Illegal command: fault pulses the next cycle, the FSM stays in IDLE, SP is unchanged, and mem_req is never raised.
- ADJ/SET legal: SP updates at the next edge and done pulses the next cycle. busy is never raised.
- PUSH/POP with n=0: FSM goes to FIN, then done pulses. No transfers occur.
- PUSH (full-descending):
  - Registers go highest set bit first (LR first, then descending register index).
  - Each transfer: mem_addr = SP − WORD_BYTES; on ack, SP −= WORD_BYTES.
- POP:
  - Registers go lowest set bit first (PC last).
  - Each transfer: mem_addr = SP; on ack, SP += WORD_BYTES.
  - On the ack cycle, rf_we pulses (or pc_we for bit NREG).
- After each ack, the serviced bit is cleared from the working list. When the list is empty, the FSM goes to FIN.
- Arithmetic is modulo 2^ADDR_W internally. A legal command can never wrap, because wrapping is excluded by the bounds check.

## Timing

- Reset values: busy=0, done=0, fault=0, mem_req=0, mem_we=0, mem_addr=0, reg_idx=0, lr_sel=0, rf_we=0, pc_we=0, sp_out=SP_RESET. FSM state is IDLE.
- busy rises the cycle after a legal PUSH/POP start. It falls in the same cycle done pulses.
- While busy=1, start is ignored.
- mem_req is registered. mem_addr, mem_we, reg_idx and lr_sel stay stable while mem_req=1 and mem_ack=0.
- With mem_ack tied high, a transfer completes every cycle, so an n-register list takes n+2 cycles from start to done.
- rf_we and pc_we are combinational with mem_ack, and only while mem_req=1 and mem_we=0.
- If mem_ack arrives while mem_req=0, it is ignored.
- Reset asserted mid-sequence: all outputs take their reset values immediately and SP returns to SP_RESET. The outstanding request is abandoned, with no done or fault.

## Structure

- Shared package stack_pkg: op encodings (ST_PUSH, ST_POP, ST_ADJ, ST_SET) and the state enum.
- Sub-module stack_prio_enc: parametrised NREG+1-bit priority encoder with a direction input (highest/lowest) and outputs idx and valid. It is instantiated once and driven by the working list.
- The popcount and bounds comparators stay inline in stack_seq.

## Test plan

All scenarios use the default parameters.

- **Reset:** assert resetn=0 mid-run → sp_out=0x5500, busy=0, mem_req=0 on the same cycle.
- **PUSH, ack tied high:** reglist=9'b1_0000_0101 → stores in order:
  - LR at 0x54FC with lr_sel=1,
  - r2 at 0x54F8,
  - r0 at 0x54F4.
  - Then done pulses; sp_out=0x54F4; 5 cycles from start to done.
- **POP, same list:** loads in order:
  - r0 from 0x54F4 (rf_we),
  - r2 from 0x54F8 (rf_we),
  - PC from 0x54FC (pc_we, no rf_we).
  - Then sp_out=0x5500.
- **Memory stall:** during PUSH of r3 only, hold mem_ack=0 for 3 cycles → mem_addr stays 0x54FC and sp_out stays 0x5500 until the ack; done follows the ack.
- **Underflow:** POP reglist=9'b0_0000_0001 at SP=0x5500 → fault pulses, mem_req stays 0, SP is unchanged. Then SET imm=0x5502 → fault (misaligned).
- **ADJ:** imm=−16 → sp_out=0x54C0 next cycle with a done pulse. Then ADJ imm=+16 → 0x5500. Then PUSH with n=0 → done with no mem_req.
